// File: rtl/clk_period_meter.sv
// clk_period_meter: measures the period and high time of a slow asynchronous
// input clock (sig_in), counted in clk_in cycles, and reports lock and timeout.
//
// Ports:
//   clk_in      - system clock; all logic uses its rising edge
//   rstn        - synchronous active-low reset
//   sig_in      - slow asynchronous input to measure
//   period_out  - last rising-edge-to-rising-edge period (clk_in cycles)
//   high_out    - clk_in cycles with sig_in high during that period
//   valid_out   - one-cycle pulse when period_out/high_out update
//   locked_out  - high while LOCK_CNT consecutive periods matched
//   timeout_out - high while no rising edge arrived within TIMEOUT cycles
module clk_period_meter #(
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned TIMEOUT  = 65535,
  parameter int unsigned LOCK_CNT = 4
) (
  input  logic             clk_in,
  input  logic             rstn,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period_out,
  output logic [CNT_W-1:0] high_out,
  output logic             valid_out,
  output logic             locked_out,
  output logic             timeout_out
);

  localparam int unsigned       MCNT_W = 4;
  localparam logic [CNT_W-1:0]  TOUT_V = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]  ONE_V  = CNT_W'(1);
  localparam logic [MCNT_W-1:0] LOCK_V = MCNT_W'(LOCK_CNT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MEAS = 2'd1,
    S_TOUT = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              s1_q, s2_q, d_q;
  logic              rise_c;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  hcnt_q, hcnt_d;
  logic [CNT_W-1:0]  period_d, high_d;
  logic [MCNT_W-1:0] mcnt_q, mcnt_d;
  logic              first_q, first_d;
  logic              valid_d, locked_d, tout_d;

  // Synchronized rising edge of sig_in
  assign rise_c = s2_q & ~d_q;

  // State register
  always_ff @(posedge clk_in) begin
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; a rise at the timeout boundary keeps us measuring
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (rise_c) state_d = S_MEAS;
      S_MEAS:  if (!rise_c && (cnt_q == TOUT_V)) state_d = S_TOUT;
      S_TOUT:  if (rise_c) state_d = S_MEAS;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    cnt_d    = cnt_q;
    hcnt_d   = hcnt_q;
    mcnt_d   = mcnt_q;
    first_d  = first_q;
    period_d = period_out;
    high_d   = high_out;
    valid_d  = 1'b0;
    locked_d = locked_out;
    tout_d   = timeout_out;
    case (state_q)
      S_IDLE, S_TOUT: begin
        // First edge after reset or timeout: start counting, no report
        if (rise_c) begin
          cnt_d   = ONE_V;
          hcnt_d  = ONE_V;
          mcnt_d  = '0;
          first_d = 1'b1;
          tout_d  = 1'b0;
        end
      end
      S_MEAS: begin
        if (rise_c) begin
          period_d = cnt_q;
          high_d   = hcnt_q;
          valid_d  = 1'b1;
          cnt_d    = ONE_V;
          hcnt_d   = ONE_V;
          first_d  = 1'b0;
          // First report after (re)start has nothing valid to compare with
          if (first_q)                   mcnt_d = '0;
          else if (cnt_q != period_out)  mcnt_d = '0;
          else if (mcnt_q != LOCK_V)     mcnt_d = mcnt_q + MCNT_W'(1);
          locked_d = (mcnt_d == LOCK_V);
        end else if (cnt_q == TOUT_V) begin
          tout_d   = 1'b1;
          locked_d = 1'b0;
          mcnt_d   = '0;
        end else begin
          // cnt_q < TOUT_V here; hcnt never exceeds cnt
          cnt_d = cnt_q + ONE_V;
          if (s2_q && (hcnt_q != TOUT_V)) hcnt_d = hcnt_q + ONE_V;
        end
      end
      default: ;
    endcase
  end

  // Synchronizer, counters and registered outputs
  always_ff @(posedge clk_in) begin
    if (!rstn) begin
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      d_q         <= 1'b0;
      cnt_q       <= '0;
      hcnt_q      <= '0;
      mcnt_q      <= '0;
      first_q     <= 1'b0;
      period_out  <= '0;
      high_out    <= '0;
      valid_out   <= 1'b0;
      locked_out  <= 1'b0;
      timeout_out <= 1'b0;
    end else begin
      s1_q        <= sig_in;
      s2_q        <= s1_q;
      d_q         <= s2_q;
      cnt_q       <= cnt_d;
      hcnt_q      <= hcnt_d;
      mcnt_q      <= mcnt_d;
      first_q     <= first_d;
      period_out  <= period_d;
      high_out    <= high_d;
      valid_out   <= valid_d;
      locked_out  <= locked_d;
      timeout_out <= tout_d;
    end
  end

endmodule

// File: tb/tb_clk_period_meter.sv
// Testbench for clk_period_meter (TIMEOUT=100, LOCK_CNT=4).
module tb_clk_period_meter;

  localparam int unsigned CNT_W    = 16;
  localparam int unsigned TIMEOUT  = 100;
  localparam int unsigned LOCK_CNT = 4;

  logic             clk_in = 1'b0;
  logic             rstn;
  logic             sig_in;
  logic [CNT_W-1:0] period_out;
  logic [CNT_W-1:0] high_out;
  logic             valid_out;
  logic             locked_out;
  logic             timeout_out;

  clk_period_meter #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT),
    .LOCK_CNT(LOCK_CNT)
  ) dut (
    .clk_in     (clk_in),
    .rstn       (rstn),
    .sig_in     (sig_in),
    .period_out (period_out),
    .high_out   (high_out),
    .valid_out  (valid_out),
    .locked_out (locked_out),
    .timeout_out(timeout_out)
  );

  always #5 clk_in = ~clk_in;

  // One sig_in period: hi cycles high then lo cycles low, and the report
  // expected when the next rising edge closes it
  typedef struct {
    int hi;
    int lo;
    int period;
    int high;
    int lock;
  } row_t;

  typedef struct {
    int period;
    int high;
    int lock;
  } exp_t;

  row_t rows[24];
  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   n_push = 0;
  int   n_pop = 0;
  bit   tout_watch = 1'b0;
  int   n0;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic push_exp(input int period, input int high, input int lock);
    exp_t e;
    e.period = period;
    e.high   = high;
    e.lock   = lock;
    sb.push_back(e);
    n_push++;
  endtask

  task automatic run_row(input row_t r);
    sig_in = 1'b1;
    repeat (r.hi) tick();
    sig_in = 1'b0;
    repeat (r.lo) tick();
    push_exp(r.period, r.high, r.lock);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_period"},  int'(period_out),  0);
    chk({tag, "_high"},    int'(high_out),    0);
    chk({tag, "_valid"},   int'(valid_out),   0);
    chk({tag, "_locked"},  int'(locked_out),  0);
    chk({tag, "_timeout"}, int'(timeout_out), 0);
  endtask

  // Scoreboard: every valid pulse pops one expected report
  always @(negedge clk_in) begin
    if (tout_watch) chk("timeout_stays_low", int'(timeout_out), 0);
    if (valid_out === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        n_pop++;
        chk("period", int'(period_out), mon_e.period);
        chk("high",   int'(high_out),   mon_e.high);
        chk("locked", int'(locked_out), mon_e.lock);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 50% divide-by-16, lock after the 5th report
    rows[0]  = '{8, 8, 16, 8, 0};
    rows[1]  = '{8, 8, 16, 8, 0};
    rows[2]  = '{8, 8, 16, 8, 0};
    rows[3]  = '{8, 8, 16, 8, 0};
    rows[4]  = '{8, 8, 16, 8, 1};
    rows[5]  = '{8, 8, 16, 8, 1};
    // one period of 17 breaks lock; relock after returning to 16
    rows[6]  = '{8, 9, 17, 8, 0};
    rows[7]  = '{8, 8, 16, 8, 0};
    rows[8]  = '{8, 8, 16, 8, 0};
    rows[9]  = '{8, 8, 16, 8, 0};
    rows[10] = '{8, 8, 16, 8, 0};
    rows[11] = '{8, 8, 16, 8, 1};
    rows[12] = '{8, 8, 16, 8, 1};
    // after timeout recovery: 25% duty at 32, then periods of exactly TIMEOUT
    rows[13] = '{8, 24, 32, 8, 0};
    rows[14] = '{8, 92, 100, 8, 0};
    rows[15] = '{8, 92, 100, 8, 0};
    rows[16] = '{8, 92, 100, 8, 0};
    // relock at 16 before the mid-period reset
    rows[17] = '{8, 8, 16, 8, 0};
    rows[18] = '{8, 8, 16, 8, 0};
    rows[19] = '{8, 8, 16, 8, 0};
    rows[20] = '{8, 8, 16, 8, 0};
    rows[21] = '{8, 8, 16, 8, 1};
    // after reset release
    rows[22] = '{8, 8, 16, 8, 0};
    rows[23] = '{8, 8, 16, 8, 0};

    rstn   = 1'b0;
    sig_in = 1'b0;
    repeat (3) tick();
    @(negedge clk_in);
    chk_all_zero("reset");
    tick();
    rstn = 1'b1;
    repeat (4) tick();

    for (int i = 0; i < 13; i++) run_row(rows[i]);

    // Last rise, then hold low until timeout
    sig_in = 1'b1;
    n0 = cyc;
    repeat (8) tick();
    sig_in = 1'b0;
    while (cyc < n0 + 102) tick();
    @(negedge clk_in);
    chk("pre_timeout_flag",   int'(timeout_out), 0);
    chk("pre_timeout_locked", int'(locked_out),  1);
    tick();
    @(negedge clk_in);
    chk("timeout_flag",        int'(timeout_out), 1);
    chk("timeout_locked",      int'(locked_out),  0);
    chk("timeout_period_hold", int'(period_out),  16);
    chk("timeout_high_hold",   int'(high_out),    8);
    repeat (5) tick();
    @(negedge clk_in);
    chk("timeout_level", int'(timeout_out), 1);

    // Rise after timeout clears the flag without a report
    sig_in = 1'b1;
    n0 = cyc;
    while (cyc < n0 + 2) tick();
    @(negedge clk_in);
    chk("timeout_before_clear", int'(timeout_out), 1);
    tick();
    @(negedge clk_in);
    chk("timeout_cleared", int'(timeout_out), 0);
    tout_watch = 1'b1;
    repeat (5) tick();
    sig_in = 1'b0;
    repeat (24) tick();
    push_exp(32, 8, 0);

    for (int i = 13; i < 22; i++) run_row(rows[i]);

    // Mid-period reset while locked
    sig_in = 1'b1;
    n0 = cyc;
    repeat (8) tick();
    sig_in = 1'b0;
    while (cyc < n0 + 10) tick();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    @(negedge clk_in);
    chk_all_zero("midreset");
    while (cyc < n0 + 16) tick();

    for (int i = 22; i < 24; i++) run_row(rows[i]);

    // Closing rise for the final row
    sig_in = 1'b1;
    repeat (8) tick();
    sig_in = 1'b0;
    repeat (8) tick();
    @(negedge clk_in);
    chk("scoreboard_empty", sb.size(), 0);
    chk("report_count", n_pop, n_push);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clk_period_meter.md
CLK_PERIOD_METER -- requirements
Module: clk_period_meter

Interface
REQ-001 Parameter CNT_W, default 16: width of period, high-time and internal cycle counters.
REQ-002 Parameter TIMEOUT, default 65535: maximum cycle count without a rising edge before a timeout is declared; legal range 2..2^CNT_W-1.
REQ-003 Parameter LOCK_CNT, default 4: number of consecutive matching measurements required for lock; legal range 1..15.
REQ-004 Port clk_in  input  1: the single system clock; all logic is clocked on its rising edge.
REQ-005 Port rstn  input  1: reset, synchronous and active-low, sampled on the rising edge of clk_in.
REQ-006 Port sig_in  input  1: slow input clock to be measured, e.g. a divided clock; asynchronous to clk_in.
REQ-007 Port period_out  output  CNT_W: last measured rising-edge-to-rising-edge period, in clk_in cycles.
REQ-008 Port high_out  output  CNT_W: clk_in cycles with sig_in high during the last measured period.
REQ-009 Port valid_out  output  1: one-cycle pulse indicating that period_out and high_out were updated.
REQ-010 Port locked_out  output  1: level, high while the period is stable per REQ-021.
REQ-011 Port timeout_out  output  1: level, high while no rising edge has arrived within TIMEOUT cycles.

Function
REQ-012 sig_in shall pass through a 2-flop synchronizer (s1, s2) followed by a delay flop d; rise = s2 & ~d.
- A sig_in rising edge sampled at clock k yields rise during cycle k+2.
REQ-013 The block shall use a 3-state FSM: IDLE, MEAS, TOUT.
REQ-014 IDLE, on rise: go to MEAS; cnt <= 1; hcnt <= 1; no valid_out; no compare history.
REQ-015 MEAS, no rise: cnt <= cnt+1 and hcnt <= hcnt+s2, both saturating at TIMEOUT.
REQ-016 MEAS, rise: at that clock edge, period_out <= cnt, high_out <= hcnt, valid_out <= 1; then cnt <= 1, hcnt <= 1.
- Reported values are therefore registered one cycle after the rise cycle.
REQ-017 valid_out shall be high for exactly one cycle per reported measurement and low in all other cycles.
REQ-018 MEAS, no rise, and cnt == TIMEOUT: go to TOUT; timeout_out <= 1; locked_out <= 0; match history cleared; period_out and high_out hold.
REQ-019 Rise and cnt == TIMEOUT in the same cycle: the rise wins; report period TIMEOUT and stay in MEAS.
REQ-020 TOUT, on rise: go to MEAS; timeout_out <= 0; cnt <= 1; hcnt <= 1; no valid_out. This rise is treated as a first edge, as in IDLE.
REQ-021 Lock tracking uses a match counter mcnt, saturating at LOCK_CNT.
- First measurement after entering MEAS: mcnt <= 0.
- Each later measurement: mcnt <= mcnt+1 if the new period equals the previous period_out; otherwise mcnt <= 0.
- locked_out shall equal (mcnt == LOCK_CNT) and update on the same edge as valid_out.
REQ-022 high_out shall never exceed period_out.
- Constant-high sig_in produces no rise and therefore times out.
- Constant-low sig_in also times out.

Reset
REQ-023 rstn low at a clock edge shall force the following state:
- FSM to IDLE.
- s1, s2, d, cnt, hcnt and mcnt to 0.
- period_out = 0, high_out = 0, valid_out = 0, locked_out = 0, timeout_out = 0.
REQ-024 Reset mid-measurement shall discard the partial count. The first rise after rstn returns high shall be handled per REQ-014 and produce no valid_out.

Verification
REQ-025 Reset release, then sig_in = 50%-duty divide-by-16 of clk_in (LOCK_CNT=4):
- First rise produces no valid.
- Thereafter valid_out pulses every 16 cycles with period_out = 16 and high_out = 8.
- locked_out = 1 from the 5th valid onward.
REQ-026 Locked at period 16, then one period of 17: that valid reports 17 and locked_out = 0. Back to 16: relock 4 valids later.
REQ-027 TIMEOUT=100, sig_in held low after lock:
- timeout_out rises exactly 100 cycles after the last rise cycle; locked_out falls on the same edge.
- Next rise clears timeout_out with no valid; the following rise reports a valid period.
REQ-028 TIMEOUT=100, rises spaced exactly 100 cycles apart: period_out = 100 and timeout_out stays 0 throughout.
REQ-029 rstn pulsed low for 1 cycle mid-period while locked: all outputs are 0 on the next cycle; the first valid after release is 2 rises later.
REQ-030 sig_in with 25% duty at period 32: period_out = 32 and high_out = 8.
